// File: rtl/rx_data_sampler.sv
// UART receive oversampling front end: tracks the tick position within each bit,
// takes three mid-bit samples and presents one majority-voted bit per bit period.
module rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  sampler_enable,
  output logic                  sampled_data,
  output logic                  sampled_data_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic [PRESCALE_W-1:0] ratio;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_tick;
  logic [PRESCALE_W-1:0] sample0_tick;
  logic [PRESCALE_W-1:0] sample1_tick;
  logic [PRESCALE_W-1:0] sample2_tick;
  logic [PRESCALE_W-1:0] vote_tick;
  logic                  s0, s1, s2;
  logic                  vote;

  // Unsupported ratios fall back to 8 so a bad setting can never stall the counter.
  always_comb begin
    ratio = PRESCALE_W'(8);
    case (prescale)
      PRESCALE_W'(8), PRESCALE_W'(16), PRESCALE_W'(32): ratio = prescale;
      default:                                          ratio = PRESCALE_W'(8);
    endcase
  end

  always_comb begin
    half         = ratio >> 1;
    last_tick    = ratio - PRESCALE_W'(1);
    sample0_tick = half - PRESCALE_W'(1);
    sample1_tick = half;
    sample2_tick = half + PRESCALE_W'(1);
    vote_tick    = half + PRESCALE_W'(2);
    vote         = (s0 & s1) | (s0 & s2) | (s1 & s2);
  end

  // Using >= for the wrap lets a stale count left by a mid-frame ratio change recover.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      edge_cnt           <= '0;
      bit_cnt            <= '0;
      sampled_data       <= 1'b1;
      sampled_data_valid <= 1'b0;
      s0                 <= 1'b1;
      s1                 <= 1'b1;
      s2                 <= 1'b1;
    end else if (!sampler_enable) begin
      edge_cnt           <= '0;
      bit_cnt            <= '0;
      sampled_data_valid <= 1'b0;
      s0                 <= 1'b1;
      s1                 <= 1'b1;
      s2                 <= 1'b1;
    end else begin
      if (edge_cnt >= last_tick) begin
        edge_cnt <= '0;
        if (bit_cnt != {BIT_CNT_W{1'b1}}) begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end

      if (edge_cnt == sample0_tick) s0 <= rx_in;
      if (edge_cnt == sample1_tick) s1 <= rx_in;
      if (edge_cnt == sample2_tick) s2 <= rx_in;

      sampled_data_valid <= 1'b0;
      if (edge_cnt == vote_tick) begin
        sampled_data       <= vote;
        sampled_data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rx_data_sampler.md
Name: rx_data_sampler

Overview:
- Oversampling front end of the UART receiver.
- Runs on the prescaled oversampling clock and tracks the position inside each serial bit with an edge counter.
- Takes three samples around mid-bit, resolves them by majority vote, and presents one bit per bit-period as sampled_data with a one-cycle sampled_data_valid strobe.
- Directly feeds parity_check and the deserializer. It also exports edge/bit counters so the receive FSM can generate parity_check_enable and stop/start checks.

Parameters:
- PRESCALE_W, 6, width of the prescale input and the edge counter.
- BIT_CNT_W, 4, width of the bit counter.

Ports:
- clk_based_on_prescale  input  1  oversampling clock (prescale ticks per UART bit).
- asy_reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, already synchronised to clk_based_on_prescale; idle high.
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- sampler_enable  input  1  high while a frame is being received; driven by the RX FSM.
- sampled_data  output  1  majority-voted bit value.
- sampled_data_valid  output  1  one-cycle strobe, sampled_data is new.
- edge_cnt  output  PRESCALE_W  oversampling tick position within current bit, 0..P-1.
- bit_cnt  output  BIT_CNT_W  index of current bit within frame (0 = start bit).

Behaviour:
- Reset (asy_reset low, async):
  - edge_cnt=0, bit_cnt=0.
  - sampled_data=1, sampled_data_valid=0.
  - Internal sample registers s0,s1,s2 = 1.
- Effective ratio P:
  - P = prescale when prescale is 8, 16 or 32.
  - Any other value uses P=8.
  - P is evaluated every cycle. Software changes prescale only while sampler_enable=0; a mid-frame change is undefined but must not lock up. Any edge_cnt >= P wraps to 0 on the next tick.
- Let M = P/2.
- sampler_enable=0:
  - edge_cnt and bit_cnt cleared to 0 on the next clock.
  - sampled_data_valid=0; sampled_data holds its last value.
  - s0..s2 reset to 1.
- sampler_enable=1, every clock:
  - Edge counter:
    - edge_cnt increments.
    - When edge_cnt==P-1 it wraps to 0 and bit_cnt increments.
    - bit_cnt saturates at all-ones and does not wrap.
  - Alignment: the first enabled cycle has edge_cnt=0, which is the start-bit falling-edge tick detected by the FSM.
  - Sampling: when edge_cnt == M-1, M, M+1, capture rx_in into s0, s1, s2 respectively.
  - Vote: when edge_cnt == M+2:
    - sampled_data <= majority(s0,s1,s2) = (s0&s1)|(s0&s2)|(s1&s2).
    - sampled_data_valid <= 1.
  - sampled_data_valid is high for exactly one clock per bit, during the tick where edge_cnt reads M+3.
  - Latency from the last sample tick to the valid strobe is 2 clocks.
  - Valid is deasserted on all other ticks.
- Exactly one valid strobe per bit period, including the start and stop bits. The consumer uses its own enables to ignore bits it does not want.
- sampler_enable dropped mid-bit:
  - Counters clear on the next clock.
  - A vote in flight is discarded.
  - No valid is emitted after the deassert edge.
- sampler_enable re-asserted the cycle after dropping: treated as a fresh start; edge_cnt restarts from 0.
- Reset mid-frame aborts immediately to the reset values.

Test Plan:
- Reset: hold asy_reset low 3 cycles, with rx_in and sampler_enable toggling -> sampled_data=1, valid=0, edge_cnt=0, bit_cnt=0 throughout.
- P=8, clean frame:
  - Stimulus: enable, drive start=0 then data 8'hA5 LSB first, each bit 8 ticks.
  - Required: valid pulses at ticks 7, 15, 23, ... counted from enable.
  - sampled_data sequence is 0,1,0,1,0,0,1,0,1.
  - bit_cnt reads 0..8 across bits.
- P=16, glitch rejection:
  - Stimulus: bit value 1 with rx_in forced 0 only at edge_cnt==8.
  - Required: sampled_data=1 with valid at edge_cnt==11.
  - Two bad samples (edge_cnt 7 and 8 forced 0) -> sampled_data=0.
- P=32: 10-bit frame -> exactly 10 valid pulses; each at edge_cnt==19; edge_cnt wraps 31->0.
- Illegal prescale=12: behaves as P=8, with valid at edge_cnt==7 and wrap at 7.
- Abort: drop sampler_enable at edge_cnt==M (P=8, tick 4 of bit 2) -> no valid for that bit; edge_cnt=0 and bit_cnt=0 the next clock; re-enable restarts a clean frame correctly.
